i2c_master: RTL

Single-byte I2C bus master that drives `sclk` and `sda` toward the I2C slave stage on the same two-wire bus. On a `start` request it issues START, the 7-bit address plus R/W bit, and checks the address ACK. It then either writes one data byte and checks its ACK, or reads one byte and returns NACK, and finishes with STOP. It sits between the system-clock control logic and the bus.

---
 rtl/i2c_master.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/i2c_master.sv
// Single-byte I2C master: START, address + R/W, one data byte written or read, STOP.
// A transaction takes 80*CLK_DIV cycles (44*CLK_DIV on address NACK); start is ignored while busy.
module i2c_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       r_w,
  input  logic [6:0] slave_addr,
  input  logic [7:0] data_in,
  output logic       sclk,
  inout  wire        sda,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       done,
  output logic       ack_error
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_NACK, STOP
  } state_t;

  state_t          state, nxt_state;
  logic [DW-1:0]   div;
  logic [1:0]      phase, nxt_phase;
  logic [2:0]      bit_cnt, nxt_bit;
  logic [7:0]      addr_rw, wdata, rx_sr;
  logic            samp;
  logic            sda_en, sda_out;
  logic            tick, accept;
  logic            tx_bit, nxt_sclk, nxt_en, nxt_out;

  assign sda    = sda_en ? sda_out : 1'bz;
  assign tick   = (state != IDLE) && (div == DW'(CLK_DIV - 1));
  assign accept = (state == IDLE) && start;

  always_comb begin
    nxt_state = state;
    nxt_phase = phase;
    nxt_bit   = bit_cnt;
    if (accept) begin
      nxt_state = START;
      nxt_phase = 2'd0;
      nxt_bit   = 3'd0;
    end else if (tick) begin
      nxt_phase = phase + 2'd1;
      if (phase == 2'd3) begin
        case (state)
          START:     nxt_state = ADDR;
          ADDR: begin
            nxt_bit = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) nxt_state = ADDR_ACK;
          end
          ADDR_ACK:  nxt_state = samp ? STOP : (addr_rw[0] ? READ : WRITE);
          WRITE: begin
            nxt_bit = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) nxt_state = WRITE_ACK;
          end
          WRITE_ACK: nxt_state = STOP;
          READ: begin
            nxt_bit = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) nxt_state = READ_NACK;
          end
          READ_NACK: nxt_state = STOP;
          default:   nxt_state = IDLE;
        endcase
      end
    end
  end

  // Bus levels are computed for the upcoming state/phase so the registered pins line up with it.
  always_comb begin
    tx_bit   = (nxt_state == WRITE) ? wdata[3'd7 - nxt_bit] : addr_rw[3'd7 - nxt_bit];
    nxt_sclk = (nxt_phase == 2'd1) || (nxt_phase == 2'd2);
    nxt_en   = 1'b0;
    nxt_out  = 1'b0;
    case (nxt_state)
      IDLE:  nxt_sclk = 1'b1;
      START: begin
        nxt_sclk = (nxt_phase != 2'd3);
        nxt_en   = nxt_phase[1];
      end
      ADDR, WRITE: begin
        nxt_en  = 1'b1;
        nxt_out = tx_bit;
      end
      STOP: begin
        nxt_sclk = (nxt_phase != 2'd0);
        nxt_en   = (nxt_phase != 2'd3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      div       <= '0;
      phase     <= 2'd0;
      bit_cnt   <= 3'd0;
      sclk      <= 1'b1;
      sda_en    <= 1'b0;
      sda_out   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ack_error <= 1'b0;
      data_out  <= 8'h00;
      addr_rw   <= 8'h00;
      wdata     <= 8'h00;
      rx_sr     <= 8'h00;
      samp      <= 1'b0;
    end else begin
      state   <= nxt_state;
      phase   <= nxt_phase;
      bit_cnt <= nxt_bit;
      sclk    <= nxt_sclk;
      sda_en  <= nxt_en;
      sda_out <= nxt_out;
      done    <= 1'b0;
      if (state == IDLE) div <= '0;
      else               div <= tick ? '0 : div + 1'b1;
      if (accept) begin
        addr_rw   <= {slave_addr, r_w};
        wdata     <= data_in;
        busy      <= 1'b1;
        ack_error <= 1'b0;
      end
      // Entering phase 2: SCL has been high a full quarter, the slave's level is settled.
      if (tick && phase == 2'd1) begin
        samp <= sda;
        if (state == READ) rx_sr <= {rx_sr[6:0], sda};
        if ((state == ADDR_ACK || state == WRITE_ACK) && sda) ack_error <= 1'b1;
      end
      if (tick && phase == 2'd3) begin
        if (state == READ_NACK) data_out <= rx_sr;
        if (state == STOP) begin
          done <= 1'b1;
          busy <= 1'b0;
        end
      end
    end
  end

endmodule
